lc3_mem_arbiter: RTL and testbench

- Sits between the processor's split instruction/data memory ports and the single-ported physical memory model.
- Serialises instruction and data requests onto one memory port.
- Routes the shared response back as separate per-port response strobes.
- Registers the granted request so the memory sees stable address, data and enables for the whole transaction.

---
 rtl/lc3_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// Serialises the split instruction/data memory ports onto one physical port.
// Define LC3_MEM_ARB_RR_EN for round-robin arbitration (default: data priority).
module lc3_mem_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int BE_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  inst_mem_read,
    input  logic                  inst_mem_write,
    input  logic [BE_WIDTH-1:0]   inst_mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] inst_mem_addr,
    input  logic [DATA_WIDTH-1:0] inst_mem_wdata,
    output logic [DATA_WIDTH-1:0] inst_mem_rdata,
    output logic                  inst_mem_resp,

    input  logic                  data_mem_read,
    input  logic                  data_mem_write,
    input  logic [BE_WIDTH-1:0]   data_mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] data_mem_addr,
    input  logic [DATA_WIDTH-1:0] data_mem_wdata,
    output logic [DATA_WIDTH-1:0] data_mem_rdata,
    output logic                  data_mem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [BE_WIDTH-1:0]   pmem_byte_enable,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tmo_q, tmo_d;
`ifdef LC3_MEM_ARB_RR_EN
    logic                  rr_q, rr_d;
`endif

    logic inst_req;
    logic data_req;
    logic grant_data;
    logic busy;

    assign inst_req = inst_mem_read | inst_mem_write;
    assign data_req = data_mem_read | data_mem_write;
    assign busy     = (state_q != IDLE);

    // rr_q remembers the last winner (1 = data); the other port wins a tie.
    always_comb begin
        grant_data = data_req;
`ifdef LC3_MEM_ARB_RR_EN
        if (inst_req && data_req) begin
            grant_data = ~rr_q;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        inst_rdata_d  = inst_rdata_q;
        data_rdata_d  = data_rdata_q;
        cnt_d         = cnt_q;
        tmo_d         = 1'b0;
        inst_mem_resp = 1'b0;
        data_mem_resp = 1'b0;
`ifdef LC3_MEM_ARB_RR_EN
        rr_d          = rr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    cnt_d = '0;
`ifdef LC3_MEM_ARB_RR_EN
                    rr_d  = grant_data;
`endif
                    if (grant_data) begin
                        state_d = BUSY_D;
                        wr_d    = data_mem_write;
                        addr_d  = data_mem_addr;
                        wdata_d = data_mem_wdata;
                        be_d    = data_mem_byte_enable;
                    end else begin
                        state_d = BUSY_I;
                        wr_d    = inst_mem_write;
                        addr_d  = inst_mem_addr;
                        wdata_d = inst_mem_wdata;
                        be_d    = inst_mem_byte_enable;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    if (state_q == BUSY_I) begin
                        inst_mem_resp = 1'b1;
                        inst_rdata_d  = pmem_rdata;
                    end else begin
                        data_mem_resp = 1'b1;
                        data_rdata_d  = pmem_rdata;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q != CNT_MAX) begin
                    // Saturates at the limit so the error fires only once.
                    cnt_d = cnt_q + CNT_W'(1);
                    tmo_d = (cnt_q == CNT_PRE);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
`ifdef LC3_MEM_ARB_RR_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
`ifdef LC3_MEM_ARB_RR_EN
            rr_q         <= rr_d;
`endif
        end
    end

    assign pmem_read        = busy & ~wr_q;
    assign pmem_write       = busy & wr_q;
    assign pmem_addr        = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
    assign timeout_err      = tmo_q;

    // The granted port sees memory data in the resp cycle itself.
    assign inst_mem_rdata = inst_mem_resp ? pmem_rdata : inst_rdata_q;
    assign data_mem_rdata = data_mem_resp ? pmem_rdata : data_rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level memory/arbiter model.
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_mem_read, inst_mem_write;
    logic [1:0]  inst_mem_byte_enable;
    logic [15:0] inst_mem_addr, inst_mem_wdata, inst_mem_rdata;
    logic        inst_mem_resp;
    logic        data_mem_read, data_mem_write;
    logic [1:0]  data_mem_byte_enable;
    logic [15:0] data_mem_addr, data_mem_wdata, data_mem_rdata;
    logic        data_mem_resp;
    logic        pmem_read, pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;
    logic        pmem_resp;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] mem [0:32767];

    always #5 clk = ~clk;

    lc3_mem_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .BE_WIDTH(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_mem_read(inst_mem_read), .inst_mem_write(inst_mem_write),
        .inst_mem_byte_enable(inst_mem_byte_enable),
        .inst_mem_addr(inst_mem_addr), .inst_mem_wdata(inst_mem_wdata),
        .inst_mem_rdata(inst_mem_rdata), .inst_mem_resp(inst_mem_resp),
        .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
        .data_mem_byte_enable(data_mem_byte_enable),
        .data_mem_addr(data_mem_addr), .data_mem_wdata(data_mem_wdata),
        .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .timeout_err(timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        inst_mem_read = 0; inst_mem_write = 0; inst_mem_byte_enable = 2'b11;
        inst_mem_addr = 0; inst_mem_wdata = 0;
        data_mem_read = 0; data_mem_write = 0; data_mem_byte_enable = 2'b11;
        data_mem_addr = 0; data_mem_wdata = 0;
        pmem_resp = 0; pmem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        if (be[0]) mem[a[15:1]][7:0] = d[7:0];
        if (be[1]) mem[a[15:1]][15:8] = d[15:8];
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({pmem_read, pmem_write, inst_mem_resp, data_mem_resp, timeout_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {pmem_read, pmem_write, inst_mem_resp, data_mem_resp, timeout_err});
        end
        vectors++;
        if ({pmem_addr, pmem_wdata, pmem_byte_enable} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_pmem got %h/%h/%b want 0", pmem_addr, pmem_wdata, pmem_byte_enable);
        end
        vectors++;
        if ({inst_mem_rdata, data_mem_rdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata got %h/%h want 0", inst_mem_rdata, data_mem_rdata);
        end
    endtask

    task automatic test_inst_read();
        inst_mem_read = 1; inst_mem_addr = 16'h3000;
        #1;
        vectors++;
        if (pmem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL ird_latency got pmem_read=%b want 0", pmem_read);
        end
        step(); #1;
        vectors++;
        if ({pmem_read, pmem_write, pmem_addr} !== {2'b10, 16'h3000}) begin
            miscompares++;
            $display("FAIL ird_issue got r%b w%b a%h want r1 w0 a3000", pmem_read, pmem_write, pmem_addr);
        end
        step(); step();
        pmem_resp = 1; pmem_rdata = 16'h1234;
        #1;
        vectors++;
        if ({inst_mem_resp, data_mem_resp, inst_mem_rdata} !== {2'b10, 16'h1234}) begin
            miscompares++;
            $display("FAIL ird_resp got i%b d%b rd%h want i1 d0 rd1234",
                     inst_mem_resp, data_mem_resp, inst_mem_rdata);
        end
        vectors++;
        if (data_mem_rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL ird_d_hold got %h want 0000", data_mem_rdata);
        end
        step();
        pmem_resp = 0; pmem_rdata = 16'h0BAD; inst_mem_read = 0;
        #1;
        vectors++;
        if ({pmem_read, inst_mem_resp, inst_mem_rdata} !== {2'b00, 16'h1234}) begin
            miscompares++;
            $display("FAIL ird_after got r%b i%b rd%h want r0 i0 rd1234",
                     pmem_read, inst_mem_resp, inst_mem_rdata);
        end
    endtask

    task automatic test_data_write();
        int pulses = 0;
        logic [7:0] lo_before;
        lo_before = mem[15'h2000][7:0];
        data_mem_write = 1; data_mem_addr = 16'h4001;
        data_mem_byte_enable = 2'b10; data_mem_wdata = 16'hAB00;
        step(); #1;
        vectors++;
        if ({pmem_read, pmem_write, pmem_addr, pmem_byte_enable, pmem_wdata} !==
            {2'b01, 16'h4001, 2'b10, 16'hAB00}) begin
            miscompares++;
            $display("FAIL dwr_issue got r%b w%b a%h be%b wd%h want r0 w1 a4001 be10 wdAB00",
                     pmem_read, pmem_write, pmem_addr, pmem_byte_enable, pmem_wdata);
        end
        pmem_resp = 1; pmem_rdata = 16'h5555;
        #1;
        mem_write(pmem_addr, pmem_byte_enable, pmem_wdata);
        if (data_mem_resp === 1'b1) pulses++;
        vectors++;
        if (inst_mem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL dwr_iresp got %b want 0", inst_mem_resp);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            data_mem_write = 0; pmem_resp = 0;
            #1;
            if (data_mem_resp === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL dwr_pulses got %0d want 1", pulses);
        end
        vectors++;
        if (mem[15'h2000] !== {8'hAB, lo_before}) begin
            miscompares++;
            $display("FAIL dwr_mem got %h want %h", mem[15'h2000], {8'hAB, lo_before});
        end
    endtask

    task automatic test_simultaneous();
        bit pend_i, pend_d, got, win_d;
        bit last_d = 0;
        do_reset();
        for (int pair = 0; pair < 2; pair++) begin
            pend_i = 1; pend_d = 1;
            inst_mem_read = 1; inst_mem_addr = 16'h3002;
            data_mem_read = 1; data_mem_addr = 16'h5000;
            for (int k = 0; k < 2; k++) begin
                got = 0;
                for (int c = 0; c < 10 && !got; c++) begin
                    step(); #1;
                    if (pmem_read === 1'b1) got = 1;
                end
                vectors++;
                if (!got) begin
                    miscompares++;
                    $display("FAIL sim_grant_wait pair %0d slot %0d got none want pmem_read", pair, k);
                end else begin
`ifdef LC3_MEM_ARB_RR_EN
                    win_d = (pend_i && pend_d) ? !last_d : pend_d;
`else
                    win_d = pend_d;
`endif
                    vectors++;
                    if (pmem_addr !== (win_d ? 16'h5000 : 16'h3002)) begin
                        miscompares++;
                        $display("FAIL sim_order pair %0d slot %0d got %h want %h",
                                 pair, k, pmem_addr, win_d ? 16'h5000 : 16'h3002);
                    end
                    pmem_resp = 1; pmem_rdata = 16'hC000 + 16'(pair * 2 + k);
                    #1;
                    vectors++;
                    if ({inst_mem_resp, data_mem_resp} !== (win_d ? 2'b01 : 2'b10)) begin
                        miscompares++;
                        $display("FAIL sim_resp pair %0d slot %0d got %b want %b", pair, k,
                                 {inst_mem_resp, data_mem_resp}, win_d ? 2'b01 : 2'b10);
                    end
                    last_d = win_d;
                    if (win_d) pend_d = 0; else pend_i = 0;
                    step();
                    pmem_resp = 0;
                    if (win_d) data_mem_read = 0; else inst_mem_read = 0;
                end
            end
            idle_inputs();
        end
    endtask

    task automatic test_mid_change();
        inst_mem_read = 1; inst_mem_addr = 16'h3000;
        step();
        inst_mem_addr = 16'h3FFF; inst_mem_wdata = 16'hFFFF; inst_mem_byte_enable = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if ({pmem_read, pmem_addr, pmem_byte_enable} !== {1'b1, 16'h3000, 2'b11}) begin
                miscompares++;
                $display("FAIL mid_hold cyc %0d got r%b a%h be%b want r1 a3000 be11",
                         c, pmem_read, pmem_addr, pmem_byte_enable);
            end
            step();
        end
        pmem_resp = 1; pmem_rdata = 16'h7777;
        #1;
        vectors++;
        if ({inst_mem_resp, inst_mem_rdata} !== {1'b1, 16'h7777}) begin
            miscompares++;
            $display("FAIL mid_resp got %b/%h want 1/7777", inst_mem_resp, inst_mem_rdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        inst_mem_read = 1; inst_mem_addr = 16'h3000;
        step();
        step();
        rst_n = 0; inst_mem_read = 0;
        step();
        rst_n = 1;
        #1;
        vectors++;
        if ({pmem_read, pmem_write, pmem_addr, inst_mem_rdata} !== 34'h0) begin
            miscompares++;
            $display("FAIL rstmid_state got r%b w%b a%h rd%h want 0",
                     pmem_read, pmem_write, pmem_addr, inst_mem_rdata);
        end
        step();
        pmem_resp = 1; pmem_rdata = 16'hBEEF;
        #1;
        vectors++;
        if ({inst_mem_resp, data_mem_resp, inst_mem_rdata} !== 18'h0) begin
            miscompares++;
            $display("FAIL rstmid_late got i%b d%b rd%h want 0 0 0000",
                     inst_mem_resp, data_mem_resp, inst_mem_rdata);
        end
        step();
        pmem_resp = 0;
    endtask

    task automatic test_watchdog();
        int pulses = 0;
        int first = -1;
        inst_mem_read = 1; inst_mem_addr = 16'h3100;
        step();
        for (int c = 0; c < 14; c++) begin
            #1;
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            vectors++;
            if (pmem_read !== 1'b1) begin
                miscompares++;
                $display("FAIL wd_hold cyc %0d got pmem_read=%b want 1", c, pmem_read);
            end
            step();
        end
        vectors++;
        if (pulses != 1 || first != 8) begin
            miscompares++;
            $display("FAIL wd_pulse got %0d pulses first at %0d want 1 at 8", pulses, first);
        end
        pmem_resp = 1; pmem_rdata = 16'h2222;
        #1;
        vectors++;
        if (inst_mem_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_finish got %b want 1", inst_mem_resp);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        bit          act [2];
        bit          rd [2];
        bit          wr [2];
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        logic [1:0]  be [2];
        logic [15:0] exp_rd [2];
        bit          busy = 0;
        bit          last_d = 0;
        int          port = 0;
        int          lat = 0;
        int          age = 0;
        bit          cwr, exp_ir, exp_dr, win_d;
        logic [15:0] cad, cwd;
        logic [1:0]  cbe;
        do_reset();
        exp_rd[0] = 0; exp_rd[1] = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && cyc < 1500 && $urandom_range(2) == 0) begin
                    int op;
                    op = $urandom_range(2);
                    act[p] = 1;
                    rd[p] = (op != 1);
                    wr[p] = (op != 0);
                    ad[p] = 16'h3000 | 16'($urandom_range(15));
                    wd[p] = 16'($urandom);
                    be[p] = 2'($urandom_range(1, 3));
                end
            end
            inst_mem_read  = act[0] & rd[0];
            inst_mem_write = act[0] & wr[0];
            inst_mem_addr  = act[0] ? ad[0] : 16'($urandom);
            inst_mem_wdata = act[0] ? wd[0] : 16'($urandom);
            inst_mem_byte_enable = act[0] ? be[0] : 2'($urandom);
            data_mem_read  = act[1] & rd[1];
            data_mem_write = act[1] & wr[1];
            data_mem_addr  = act[1] ? ad[1] : 16'($urandom);
            data_mem_wdata = act[1] ? wd[1] : 16'($urandom);
            data_mem_byte_enable = act[1] ? be[1] : 2'($urandom);
            pmem_resp = 0;
            pmem_rdata = 16'($urandom);
            if (busy) begin
                age++;
                if (age == lat) begin
                    pmem_resp = 1;
                    if (!cwr) pmem_rdata = mem[cad[15:1]];
                end
            end else if ($urandom_range(7) == 0) begin
                pmem_resp = 1;
            end
            #1;
            vectors++;
            if (pmem_read !== (busy && !cwr) || pmem_write !== (busy && cwr)) begin
                miscompares++;
                $display("FAIL rnd_ctrl cyc %0d got r%b w%b want r%b w%b",
                         cyc, pmem_read, pmem_write, busy && !cwr, busy && cwr);
            end
            if (busy) begin
                vectors++;
                if ({pmem_addr, pmem_wdata, pmem_byte_enable} !== {cad, cwd, cbe}) begin
                    miscompares++;
                    $display("FAIL rnd_bus cyc %0d got %h/%h/%b want %h/%h/%b",
                             cyc, pmem_addr, pmem_wdata, pmem_byte_enable, cad, cwd, cbe);
                end
            end
            exp_ir = busy && port == 0 && pmem_resp;
            exp_dr = busy && port == 1 && pmem_resp;
            vectors++;
            if (inst_mem_resp !== exp_ir || data_mem_resp !== exp_dr) begin
                miscompares++;
                $display("FAIL rnd_resp cyc %0d got i%b d%b want i%b d%b",
                         cyc, inst_mem_resp, data_mem_resp, exp_ir, exp_dr);
            end
            vectors++;
            if (inst_mem_rdata !== (exp_ir ? pmem_rdata : exp_rd[0]) ||
                data_mem_rdata !== (exp_dr ? pmem_rdata : exp_rd[1])) begin
                miscompares++;
                $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", cyc,
                         inst_mem_rdata, data_mem_rdata,
                         exp_ir ? pmem_rdata : exp_rd[0], exp_dr ? pmem_rdata : exp_rd[1]);
            end
            vectors++;
            if (timeout_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_timeout cyc %0d got %b want 0", cyc, timeout_err);
            end
            if (busy && pmem_resp) begin
                if (cwr) mem_write(cad, cbe, cwd);
                exp_rd[port] = pmem_rdata;
                act[port] = 0;
                busy = 0;
            end else if (!busy && (act[0] || act[1])) begin
`ifdef LC3_MEM_ARB_RR_EN
                win_d = (act[0] && act[1]) ? !last_d : act[1];
`else
                win_d = act[1];
`endif
                port = win_d ? 1 : 0;
                last_d = win_d;
                busy = 1;
                cwr = wr[port];
                cad = ad[port];
                cwd = wd[port];
                cbe = be[port];
                lat = $urandom_range(1, 5);
                age = 0;
            end
            step();
        end
        vectors++;
        if (busy || act[0] || act[1]) begin
            miscompares++;
            $display("FAIL rnd_drain got busy=%b act=%b%b want all idle", busy, act[0], act[1]);
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hA5C3;
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_inst_read();
        test_data_write();
        test_simultaneous();
        test_mid_change();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
